// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Consumer-side controller for a synchronous FIFO read port. Pops words in
//   bursts of BURST_LEN and presents them on a valid/ready stream with m_last
//   on the final beat of each burst. A partial FIFO left untouched for TIMEOUT
//   cycles is flushed as a short burst.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   fifo_r_en       : FIFO pop strobe (combinational)
//   fifo_r_data     : FIFO read data, valid in the cycle fifo_r_en is high
//   fifo_empty      : FIFO empty flag
//   fifo_count      : FIFO occupancy
//   m_valid/m_ready : output stream handshake (m_valid registered)
//   m_data, m_last  : output word and end-of-burst marker (registered)
//   busy            : high while a burst or flush is in progress
//   bursts_done     : completed burst counter, wraps at 16 bits
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_count,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           bursts_done
);

  localparam int PW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pops_left_q, pops_left_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         timer_inc;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [15:0]           bursts_q, bursts_d;
  logic                  pop;
  logic                  xfer;

  always_comb begin
    state_d     = state_q;
    pops_left_d = pops_left_q;
    timer_d     = timer_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    bursts_d    = bursts_q;
    pop         = 1'b0;
    xfer        = m_valid_q & m_ready;
    timer_inc   = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fifo_count >= 8'(BURST_LEN)) begin
          state_d     = BURST;
          pops_left_d = PW'(BURST_LEN);
          timer_d     = '0;
        end else if (!fifo_empty) begin
          // The cycle whose increment brings the timer to TIMEOUT is the
          // last idle one; fifo_count < BURST_LEN here, so it fits in PW.
          if (timer_inc == TW'(TIMEOUT)) begin
            state_d     = FLUSH;
            pops_left_d = PW'(fifo_count);
            timer_d     = '0;
          end else begin
            timer_d = timer_inc;
          end
        end else begin
          timer_d = '0;
        end
      end

      default: begin
        // Pop only when the output register is free or draining this cycle.
        pop = (pops_left_q != '0) & ~fifo_empty & (~m_valid_q | m_ready);
        if (pop) begin
          m_valid_d   = 1'b1;
          m_data_d    = fifo_r_data;
          m_last_d    = (pops_left_q == PW'(1));
          pops_left_d = pops_left_q - PW'(1);
        end else if (xfer) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d  = IDLE;
            bursts_d = bursts_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pops_left_q <= '0;
      timer_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      pops_left_q <= pops_left_d;
      timer_q     <= timer_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      bursts_q    <= bursts_d;
    end
  end

  assign fifo_r_en   = pop;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q != IDLE);
  assign bursts_done = bursts_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: behavioural FIFO, output monitor and a
// burst-chunking reference model (BURST_LEN=4, TIMEOUT=16, DATA_WIDTH=8).
module tb_fifo_burst_reader;

  localparam int BL = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_r_en;
  logic [7:0] fifo_r_data;
  logic       fifo_empty;
  logic [7:0] fifo_count;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic [15:0] bursts_done;

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_r_en(fifo_r_en), .fifo_r_data(fifo_r_data),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bad_pop = 0;
  int stall_viol = 0;
  int exp_bursts = 0;

  // Behavioural FIFO
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_r_data = mem[rd_ptr[7:0]];
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_count  = 8'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      if (wr_ptr == rd_ptr) bad_pop++;
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Output monitor: collects transferred beats and checks stall stability
  logic [8:0] beats[$];
  logic [8:0] exp_q[$];
  logic [7:0] sent[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stall_viol++;
      if (m_valid && m_ready) beats.push_back({m_last, m_data});
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    sent.push_back(d);
  endtask

  // Reference: n words all present in the FIFO leave as full bursts of BL,
  // then the remainder as one flush burst; m_last on each chunk's final word.
  function automatic int model_append(input int lo, input int n);
    int chunks = 0;
    int i = 0;
    while (i < n) begin
      int len = (n - i >= BL) ? BL : (n - i);
      for (int j = 0; j < len; j++)
        exp_q.push_back({(j == len - 1), sent[lo + i + j]});
      i += len;
      chunks++;
    end
    return chunks;
  endfunction

  task automatic wait_bursts(input int budget, input bit rnd);
    int n = 0;
    while (bursts_done !== 16'(exp_bursts) && n < budget) begin
      if (rnd) m_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
    checks++;
    if (bursts_done !== 16'(exp_bursts)) begin
      errors++;
      $display("FAIL wait_bursts: bursts_done=%0d required %0d", bursts_done, exp_bursts);
    end
  endtask

  task automatic test_reset();
    logic ev, er, el, eb;
    rst_n = 1'b0;
    m_ready = 1'b1;
    sent.delete();
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({fifo_r_en, m_valid, m_data, m_last, busy, bursts_done} !== '0) begin
        errors++;
        $display("FAIL reset_hold: r_en=%b v=%b d=%h l=%b busy=%b bd=%0d required all 0",
                 fifo_r_en, m_valid, m_data, m_last, busy, bursts_done);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_bursts = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      er = (cyc >= 1 && cyc <= 4);
      ev = (cyc >= 2 && cyc <= 5);
      el = (cyc == 5);
      eb = (cyc >= 1 && cyc <= 5);
      @(negedge clk);
      checks += 3;
      if (fifo_r_en !== er) begin errors++; $display("FAIL full_r_en c%0d: got %b required %b", cyc, fifo_r_en, er); end
      if (m_valid !== ev)   begin errors++; $display("FAIL full_valid c%0d: got %b required %b", cyc, m_valid, ev); end
      if (busy !== eb)      begin errors++; $display("FAIL full_busy c%0d: got %b required %b", cyc, busy, eb); end
      if (ev) begin
        checks++;
        if ({m_last, m_data} !== {el, 8'h11 + 8'(cyc - 2)}) begin
          errors++;
          $display("FAIL full_data c%0d: got %b/%h required %b/%h", cyc, m_last, m_data, el, 8'h11 + 8'(cyc - 2));
        end
      end
      @(posedge clk); #1;
    end
    exp_bursts = 1;
    checks++;
    if (bursts_done !== 16'd1) begin errors++; $display("FAIL full_bursts: got %0d required 1", bursts_done); end
  endtask

  task automatic test_backpressure();
    int nb;
    beats.delete(); sent.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    for (int cyc = 0; cyc < 10; cyc++) begin
      m_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if ({m_valid, m_last, m_data, fifo_r_en} !== {1'b1, 1'b0, 8'h12, 1'b0}) begin
          errors++;
          $display("FAIL bp_hold c%0d: v=%b l=%b d=%h r_en=%b required 1/0/12/0", cyc, m_valid, m_last, m_data, fifo_r_en);
        end
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    nb = model_append(0, 4);
    exp_bursts += nb;
    wait_bursts(50, 1'b0);
    checks++;
    if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int nb;
    beats.delete(); sent.delete(); exp_q.delete();
    push(8'hA1); push(8'hA2);
    for (int cyc = 0; cyc <= TO; cyc++) begin
      @(negedge clk);
      checks++;
      if (fifo_r_en !== (cyc == TO)) begin
        errors++;
        $display("FAIL timeout_r_en c%0d: got %b required %b", cyc, fifo_r_en, (cyc == TO));
      end
      @(posedge clk); #1;
    end
    nb = model_append(0, 2);
    exp_bursts += nb;
    wait_bursts(50, 1'b0);
    checks++;
    if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL timeout_count: got %0d required %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_beat%0d: got %h required %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_multi_burst();
    int nb;
    beats.delete(); sent.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) push(8'(i));
    nb = model_append(0, 10);
    exp_bursts += nb;
    wait_bursts(200, 1'b0);
    checks++;
    if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL multi_count: got %0d required %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL multi_beat%0d: got %h required %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush_no_extend();
    int n = 0;
    int nb;
    beats.delete(); sent.delete(); exp_q.delete();
    push(8'hC0); push(8'hC1);
    while (!busy && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_start: busy=%b required 1", busy); end
    push(8'hC2); push(8'hC3); push(8'hC4);
    nb = model_append(0, 2) + model_append(2, 3);
    exp_bursts += nb;
    wait_bursts(200, 1'b0);
    checks++;
    if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL noext_count: got %0d required %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL noext_beat%0d: got %h required %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int n, nb;
    for (int it = 0; it < 6; it++) begin
      beats.delete(); sent.delete(); exp_q.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) push(8'($urandom));
      nb = model_append(0, n);
      exp_bursts += nb;
      wait_bursts(400, 1'b1);
      checks++;
      if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", it, beats.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
        checks++;
        if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h required %h", it, i, beats[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    beats.delete(); sent.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i));
    m_ready = 1'b1;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    // cycle 3: B2 is on the output; stall it so B3/B4 stay in the FIFO
    m_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, fifo_r_en, busy, bursts_done} !== '0) begin
      errors++;
      $display("FAIL mid_reset: v=%b r_en=%b busy=%b bd=%0d required all 0", m_valid, fifo_r_en, busy, bursts_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    exp_bursts = 0;
    beats.delete();
    checks++;
    if (fifo_count !== 8'd2) begin errors++; $display("FAIL mid_left: count=%0d required 2", fifo_count); end
    nb = model_append(2, 2);
    exp_bursts += nb;
    wait_bursts(100, 1'b0);
    checks++;
    if (beats.size() !== exp_q.size()) begin errors++; $display("FAIL mid_count: got %0d required %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin errors++; $display("FAIL mid_beat%0d: got %h required %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_protocol();
    checks += 2;
    if (bad_pop !== 0)    begin errors++; $display("FAIL pop_empty: got %0d required 0", bad_pop); end
    if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d required 0", stall_viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_timeout();
    test_multi_burst();
    test_flush_no_extend();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
